// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port byte-enable RAM: write-mode names,
// clear-FSM state type and the byte-lane merge helper.
package bram_pkg;

   localparam string WM_NORMAL        = "NORMAL";
   localparam string WM_READ_FIRST    = "READ_FIRST";
   localparam string WM_WRITE_THROUGH = "WRITE_THROUGH";

   // Widest word merge_be can handle; callers size-cast into and out of it.
   localparam int MAX_DATA_W = 1024;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   typedef logic [MAX_DATA_W-1:0] word_t;
   typedef logic [MAX_BE_W-1:0]   be_t;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_CLEAR = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_t;

   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   function automatic word_t merge_be(input word_t old_w, input word_t new_w, input be_t be);
      word_t res;
      res = old_w;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bram_dp_port_pipe.sv
// Per-port read-data / read-valid pipeline with optional output register.
// Also carries a side-band bit (used for the collision flag) at read latency.
module bram_dp_port_pipe #(
   parameter int DATA_W  = 16,
   parameter int OUT_REG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_issue,
   input  logic [DATA_W-1:0] rd_word,
   input  logic              coll_in,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              coll_out
);

   logic [DATA_W-1:0] data1_d, data1_q;
   logic              vld1_d, vld1_q;
   logic              coll1_d, coll1_q;

   // Data only moves on an issued read so the output holds between reads.
   always_comb begin
      data1_d = rd_issue ? rd_word : data1_q;
      vld1_d  = rd_issue;
      coll1_d = coll_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data1_q <= '0;
         vld1_q  <= 1'b0;
         coll1_q <= 1'b0;
      end else begin
         data1_q <= data1_d;
         vld1_q  <= vld1_d;
         coll1_q <= coll1_d;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] data2_d, data2_q;
         logic              vld2_d, vld2_q;
         logic              coll2_d, coll2_q;

         always_comb begin
            data2_d = vld1_q ? data1_q : data2_q;
            vld2_d  = vld1_q;
            coll2_d = coll1_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data2_q <= '0;
               vld2_q  <= 1'b0;
               coll2_q <= 1'b0;
            end else begin
               data2_q <= data2_d;
               vld2_q  <= vld2_d;
               coll2_q <= coll2_d;
            end
         end

         assign rd_data  = data2_q;
         assign rd_valid = vld2_q;
         assign coll_out = coll2_q;
      end else begin : g_no_out_reg
         assign rd_data  = data1_q;
         assign rd_valid = vld1_q;
         assign coll_out = coll1_q;
      end
   endgenerate

endmodule

// File: rtl/bram_dp_be_sync.sv
// Single-clock true dual-port RAM with byte enables, write modes and collision flag.
// Define BRAM_DP_CLEAR_INIT_EN to zero the whole array after every reset.
module bram_dp_be_sync
   import bram_pkg::*;
#(
   parameter int    DATA_W      = 16,
   parameter int    ADDR_W      = 12,
   parameter int    DEPTH       = 4096,
   parameter int    OUT_REG     = 0,
   parameter string WRITEMODE_A = "NORMAL",
   parameter string WRITEMODE_B = "NORMAL",
   localparam int   BE_W        = be_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cea,
   input  logic [BE_W-1:0]   wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dia,
   output logic [DATA_W-1:0] doa,
   output logic              rvalida,
   input  logic              ceb,
   input  logic [BE_W-1:0]   web,
   input  logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] dib,
   output logic [DATA_W-1:0] dob,
   output logic              rvalidb,
   output logic              collision,
   output logic              init_busy
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   localparam bit A_WT       = (WRITEMODE_A == WM_WRITE_THROUGH);
   localparam bit A_RD_ON_WR = A_WT || (WRITEMODE_A == WM_READ_FIRST);
   localparam bit B_WT       = (WRITEMODE_B == WM_WRITE_THROUGH);
   localparam bit B_RD_ON_WR = B_WT || (WRITEMODE_B == WM_READ_FIRST);

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [BE_W-1:0]   be);
      return DATA_W'(merge_be(word_t'(old_w), word_t'(new_w), be_t'(be)));
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_active;
   logic              a_en, b_en, a_wr, b_wr, a_in, b_in;
   logic              same_addr, ww_coll, coll;
   logic [IDX_W-1:0]  a_idx, b_idx;
   logic [DATA_W-1:0] a_old, b_old, a_new, b_merged, b_new;
   logic [DATA_W-1:0] a_rd_word, b_rd_word;
   logic              a_rd, b_rd;
   logic              coll_a, coll_b;

   // Port decode, write-word construction and read-word selection. On a
   // write/write collision port A's merge is layered on top of port B's, so
   // shared bytes take A's data and both ports store the same word.
   always_comb begin
      a_en      = cea & ~clr_active;
      b_en      = ceb & ~clr_active;
      a_wr      = a_en & (|wea);
      b_wr      = b_en & (|web);
      a_in      = ({1'b0, addra} < DEPTH_L);
      b_in      = ({1'b0, addrb} < DEPTH_L);
      a_idx     = addra[IDX_W-1:0];
      b_idx     = addrb[IDX_W-1:0];
      a_old     = a_in ? mem[a_idx] : '0;
      b_old     = b_in ? mem[b_idx] : '0;

      same_addr = a_en & b_en & (addra == addrb);
      coll      = same_addr & (a_wr | b_wr);
      ww_coll   = same_addr & a_wr & b_wr;

      b_merged  = merge(b_old, dib, web);
      a_new     = merge(ww_coll ? b_merged : a_old, dia, wea);
      b_new     = ww_coll ? a_new : b_merged;

      a_rd      = a_en & (~a_wr | A_RD_ON_WR);
      b_rd      = b_en & (~b_wr | B_RD_ON_WR);
      a_rd_word = (a_wr & A_WT) ? (a_in ? a_new : '0) : a_old;
      b_rd_word = (b_wr & B_WT) ? (b_in ? b_new : '0) : b_old;
   end

`ifdef BRAM_DP_CLEAR_INIT_EN
   localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

   clr_state_t       clr_state_q;
   logic [IDX_W-1:0] clr_addr_q;
   logic             init_busy_q;

   // Sweeps one word per cycle from reset release; IDLE already writes word 0
   // so busy covers exactly DEPTH cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_state_q <= CLR_IDLE;
         clr_addr_q  <= '0;
         init_busy_q <= 1'b1;
      end else begin
         case (clr_state_q)
            CLR_IDLE, CLR_CLEAR: begin
               if (clr_addr_q == CLR_LAST) begin
                  clr_state_q <= CLR_DONE;
                  init_busy_q <= 1'b0;
               end else begin
                  clr_state_q <= CLR_CLEAR;
                  clr_addr_q  <= clr_addr_q + 1'b1;
               end
            end
            default: begin
               clr_state_q <= CLR_DONE;
               init_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign clr_active = init_busy_q;
   assign init_busy  = init_busy_q;
`else
   assign clr_active = 1'b0;
   assign init_busy  = 1'b0;
`endif

   // Array contents are deliberately outside the reset domain.
   always_ff @(posedge clk) begin
`ifdef BRAM_DP_CLEAR_INIT_EN
      if (clr_active) begin
         mem[clr_addr_q] <= '0;
      end
`endif
      if (a_wr && a_in) begin
         mem[a_idx] <= a_new;
      end
      if (b_wr && b_in) begin
         mem[b_idx] <= b_new;
      end
   end

   bram_dp_port_pipe #(
      .DATA_W  (DATA_W),
      .OUT_REG (OUT_REG)
   ) u_pipe_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_issue (a_rd),
      .rd_word  (a_rd_word),
      .coll_in  (coll),
      .rd_data  (doa),
      .rd_valid (rvalida),
      .coll_out (coll_a)
   );

   bram_dp_port_pipe #(
      .DATA_W  (DATA_W),
      .OUT_REG (OUT_REG)
   ) u_pipe_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_issue (b_rd),
      .rd_word  (b_rd_word),
      .coll_in  (1'b0),
      .rd_data  (dob),
      .rd_valid (rvalidb),
      .coll_out (coll_b)
   );

   assign collision = coll_a | coll_b;

endmodule
